// File: rtl/uart_alu_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the UART-ALU sequencer:
//   - default operand/result width and opcode width
//   - sequencer state encoding (3 bits)
//   - helper that tells whether a state is one where the inter-byte timer runs
// -----------------------------------------------------------------------------
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_OP = 3'd1,
    S_WAIT_B  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_e;

  // The timer only guards the gaps inside a command (after operand A was seen).
  function automatic logic is_rx_state(input state_e st);
    return (st == S_WAIT_OP) || (st == S_WAIT_B);
  endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// -----------------------------------------------------------------------------
// uart_alu_timeout
// Loadable down-counter used as the inter-byte timeout of the sequencer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count cleared to 0)
//   clear       : synchronous clear of the count (highest priority)
//   load        : load load_value into the count
//   load_value  : reload value (timeout length minus one)
//   enable      : count down by one per cycle, saturating at zero
//   expire      : combinational strobe, enable high while the count is zero
// -----------------------------------------------------------------------------
module uart_alu_timeout #(
  parameter int NB_TIMER = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [NB_TIMER-1:0] load_value,
  input  logic                enable,
  output logic                expire
);

  localparam logic [NB_TIMER-1:0] CNT_ZERO = {NB_TIMER{1'b0}};
  localparam logic [NB_TIMER-1:0] CNT_ONE  = {{(NB_TIMER-1){1'b0}}, 1'b1};

  logic [NB_TIMER-1:0] count_r;

  // Count register: clear, reload or decrement towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (clear) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry is reported in the last allowed waiting cycle, so the caller can
  // leave the state on the following edge.
  assign expire = enable && (count_r == CNT_ZERO);

endmodule

// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
// Sequencer between UART rx/tx and a combinational ALU. Collects operand A,
// opcode and operand B, lets the ALU settle for one cycle, sends the result
// through the transmitter and waits for it to finish. An incomplete command
// is aborted after TIMEOUT_CYCLES idle clocks and flagged on o_err.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-low reset
//   i_rx_done      : one-cycle strobe, i_rx_data holds a received byte
//   i_rx_data      : received byte
//   i_tx_done      : one-cycle strobe, transmitter finished the frame
//   o_tx_start     : one-cycle strobe, start sending o_tx_data
//   o_tx_data      : byte to transmit (captured ALU result)
//   o_data_a/b     : ALU operands, held until overwritten
//   o_opcode       : ALU opcode (low NB_OP bits of the opcode byte)
//   i_alu_result   : combinational ALU result
//   o_busy         : high whenever the sequencer is not idle in S_WAIT_A
//   o_err          : one-cycle strobe on timeout abort
// -----------------------------------------------------------------------------
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int NB_TIMER       = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_opcode,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_err
);

  localparam logic [NB_TIMER-1:0] TIMEOUT_LOAD = NB_TIMER'(TIMEOUT_CYCLES - 1);

  state_e             state_r, state_s;
  logic [NB_DATA-1:0] data_a_r, data_a_s;
  logic [NB_DATA-1:0] data_b_r, data_b_s;
  logic [NB_OP-1:0]   opcode_r, opcode_s;
  logic [NB_DATA-1:0] tx_data_r, tx_data_s;
  logic               tx_start_r, tx_start_s;
  logic               busy_r, busy_s;
  logic               err_r, err_s;
  logic               tm_clear_s, tm_load_s, tm_enable_s, tm_expire_s;

  // A byte arriving in the expiry cycle stops the countdown, so the byte wins.
  assign tm_enable_s = is_rx_state(state_r) && !i_rx_done;

  uart_alu_timeout #(
    .NB_TIMER (NB_TIMER)
  ) u_timeout (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .clear      (tm_clear_s),
    .load       (tm_load_s),
    .load_value (TIMEOUT_LOAD),
    .enable     (tm_enable_s),
    .expire     (tm_expire_s)
  );

  // Next-state, next-register and timer-control decode.
  always_comb begin
    state_s    = state_r;
    data_a_s   = data_a_r;
    data_b_s   = data_b_r;
    opcode_s   = opcode_r;
    tx_data_s  = tx_data_r;
    tx_start_s = 1'b0;
    err_s      = 1'b0;
    tm_clear_s = 1'b0;
    tm_load_s  = 1'b0;
    case (state_r)
      S_WAIT_A: begin
        if (i_rx_done) begin
          data_a_s  = i_rx_data;
          tm_load_s = 1'b1;
          state_s   = S_WAIT_OP;
        end else begin
          tm_clear_s = 1'b1;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done) begin
          opcode_s  = i_rx_data[NB_OP-1:0];
          tm_load_s = 1'b1;
          state_s   = S_WAIT_B;
        end else if (tm_expire_s) begin
          // Abort: captured operands stay as they are.
          err_s   = 1'b1;
          state_s = S_WAIT_A;
        end else begin
          state_s = S_WAIT_OP;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done) begin
          data_b_s   = i_rx_data;
          tm_clear_s = 1'b1;
          state_s    = S_EXEC;
        end else if (tm_expire_s) begin
          err_s   = 1'b1;
          state_s = S_WAIT_A;
        end else begin
          state_s = S_WAIT_B;
        end
      end
      S_EXEC: begin
        // Operands became stable on the previous edge; the ALU output is valid now.
        tx_data_s  = i_alu_result;
        tx_start_s = 1'b1;
        tm_clear_s = 1'b1;
        state_s    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        tm_clear_s = 1'b1;
        if (i_tx_done) begin
          state_s = S_WAIT_A;
        end else begin
          state_s = S_WAIT_TX;
        end
      end
      default: begin
        tm_clear_s = 1'b1;
        state_s    = S_WAIT_A;
      end
    endcase
    // Derived from the next state so the registered flag tracks the state exactly.
    busy_s = (state_s != S_WAIT_A);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= S_WAIT_A;
      data_a_r   <= {NB_DATA{1'b0}};
      data_b_r   <= {NB_DATA{1'b0}};
      opcode_r   <= {NB_OP{1'b0}};
      tx_data_r  <= {NB_DATA{1'b0}};
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      data_a_r   <= data_a_s;
      data_b_r   <= data_b_s;
      opcode_r   <= opcode_s;
      tx_data_r  <= tx_data_s;
      tx_start_r <= tx_start_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;
  assign o_data_a   = data_a_r;
  assign o_data_b   = data_b_r;
  assign o_opcode   = opcode_r;
  assign o_busy     = busy_r;
  assign o_err      = err_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
// Directed bench for the UART-ALU sequencer. The ALU is modelled as an adder.
// Stimulus pushes the expected tx/err events into a scoreboard queue; a monitor
// pops and compares whenever o_tx_start or o_err is seen.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [5:0] opcode;
  logic [7:0] alu_result;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  assign alu_result = data_a + data_b;

  uart_alu_ctrl #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .TIMEOUT_CYCLES (TO),
    .NB_TIMER       (18)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_tx_done    (tx_done),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .o_data_a     (data_a),
    .o_data_b     (data_b),
    .o_opcode     (opcode),
    .i_alu_result (alu_result),
    .o_busy       (busy),
    .o_err        (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tx  = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] tx;
    logic [7:0] a;
    logic [5:0] op;
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every tx_start or err cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (tx_start === 1'b1 || err === 1'b1) begin
      n_cmp++;
      if (tx_start === 1'b1) n_tx++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: tx_start=%b err=%b tx_data=0x%0h at cycle %0d, expected no output",
                 tx_start, err, tx_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_err)
          mon_ok = (err === 1'b1) && (tx_start === 1'b0) && (cyc == mon_e.at);
        else
          mon_ok = (tx_start === 1'b1) && (err === 1'b0) && (tx_data === mon_e.tx) &&
                   (data_a === mon_e.a) && (opcode === mon_e.op) && (data_b === mon_e.b) &&
                   (cyc == mon_e.at);
        if (!mon_ok) begin
          n_bad++;
          $display("FAIL scoreboard: got start=%b err=%b tx=0x%0h a=0x%0h op=0x%0h b=0x%0h cyc=%0d, expected err=%b tx=0x%0h a=0x%0h op=0x%0h b=0x%0h cyc=%0d",
                   tx_start, err, tx_data, data_a, opcode, data_b, cyc,
                   mon_e.is_err, mon_e.tx, mon_e.a, mon_e.op, mon_e.b, mon_e.at);
        end
      end
    end
  end

  // Advance to the drive point just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output int s);
    rx_data = b;
    rx_done = 1'b1;
    s = cyc;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] res, input logic [7:0] a, input logic [5:0] op,
                         input logic [7:0] b, input int at);
    exp_t e;
    e.is_err = 1'b0; e.tx = res; e.a = a; e.op = op; e.b = b; e.at = at;
    sb.push_back(e);
  endtask

  task automatic push_err(input int at);
    exp_t e;
    e.is_err = 1'b1; e.tx = 8'h00; e.a = 8'h00; e.op = 6'h00; e.b = 8'h00; e.at = at;
    sb.push_back(e);
  endtask

  // Full command; the result is expected 2 cycles after the operand B strobe.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] opb, input logic [7:0] b,
                          input logic [5:0] exp_op, input logic [7:0] exp_res, input int gap);
    int s;
    send_byte(a, s);
    chk("busy_after_a", 32'(busy), 32'h1);
    idle(gap);
    send_byte(opb, s);
    idle(gap);
    send_byte(b, s);
    push_tx(exp_res, a, exp_op, b, s + 2);
  endtask

  task automatic wait_tx_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    chk("tx_start_seen", 32'(seen), 32'h1);
    tick();
  endtask

  task automatic tx_handshake();
    idle(4);
    chk("busy_in_tx", 32'(busy), 32'h1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("busy_after_tx_done", 32'(busy), 32'h0);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_data_a"}, 32'(data_a), 32'h0);
    chk({tag, "_data_b"}, 32'(data_b), 32'h0);
    chk({tag, "_opcode"}, 32'(opcode), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: end of test not reached");
    $fatal(1);
  end

  initial begin
    int s, s2, t0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data_a", 32'(data_a), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // 1: basic command with 10 idle cycles between strobes
    send_cmd(8'h53, 8'h2B, 8'h01, 6'h2B, 8'h54, 10);
    wait_tx_start();
    tx_handshake();
    // spurious tx_done while idle
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("spurious_tx_done_busy", 32'(busy), 32'h0);

    // 2: timeout in S_WAIT_B, then a full command
    send_byte(8'h10, s);
    idle(3);
    send_byte(8'h20, s);
    push_err(s + TO + 1);
    idle(TO + 5);
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_keeps_a", 32'(data_a), 32'h10);
    chk("timeout_keeps_op", 32'(opcode), 32'h20);
    chk("timeout_keeps_b", 32'(data_b), 32'h01);
    send_cmd(8'h05, 8'h20, 8'h03, 6'h20, 8'h08, 2);
    wait_tx_start();
    tx_handshake();

    // 3: operand B arrives exactly in the expiry cycle
    send_byte(8'h30, s);
    idle(2);
    send_byte(8'h02, s);
    idle(TO - 1);
    send_byte(8'h04, s2);
    push_tx(8'h34, 8'h30, 6'h02, 8'h04, s2 + 2);
    wait_tx_start();
    tx_handshake();

    // 4: byte during S_WAIT_TX is dropped
    send_cmd(8'h11, 8'h01, 8'h22, 6'h01, 8'h33, 1);
    wait_tx_start();
    send_byte(8'hFF, s);
    idle(2);
    chk("drop_data_a", 32'(data_a), 32'h11);
    chk("drop_opcode", 32'(opcode), 32'h01);
    chk("drop_data_b", 32'(data_b), 32'h22);
    tx_handshake();
    send_byte(8'h09, s);
    chk("fresh_a", 32'(data_a), 32'h09);
    chk("fresh_a_opcode_kept", 32'(opcode), 32'h01);
    chk("fresh_a_busy", 32'(busy), 32'h1);
    send_byte(8'h00, s);
    send_byte(8'h01, s);
    push_tx(8'h0A, 8'h09, 6'h00, 8'h01, s + 2);
    wait_tx_start();
    tx_handshake();

    // 5a: reset during S_WAIT_TX
    send_cmd(8'h40, 8'h03, 8'h02, 6'h03, 8'h42, 1);
    wait_tx_start();
    reset_pulse("rst_tx");
    idle(20);
    chk("rst_tx_idle_busy", 32'(busy), 32'h0);

    // 5b: reset during S_WAIT_B, no timeout error afterwards
    send_byte(8'h12, s);
    send_byte(8'h05, s);
    idle(3);
    reset_pulse("rst_b");
    idle(TO + 20);
    chk("rst_b_idle_busy", 32'(busy), 32'h0);
    send_cmd(8'h02, 8'h00, 8'h03, 6'h00, 8'h05, 1);
    wait_tx_start();
    tx_handshake();

    // 6: back-to-back commands, wraparound and opcode truncation
    t0 = n_tx;
    send_cmd(8'hFF, 8'h01, 8'h01, 6'h01, 8'h00, 0);
    wait_tx_start();
    tx_handshake();
    send_cmd(8'h7F, 8'hE0, 8'h7F, 6'h20, 8'hFE, 0);
    wait_tx_start();
    tx_handshake();
    idle(5);
    chk("two_tx_pulses", 32'(n_tx - t0), 32'd2);

    idle(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver/transmitter and the combinational ALU in the UART-ALU top.
- Collects three received bytes in the fixed order operand A, opcode, operand B, then presents them to the ALU.
- Captures the ALU result, hands it to the UART transmitter and waits for transmission to finish.
- Aborts an incomplete command after an inter-byte timeout and reports it on an error strobe.

Parameters:
NB_DATA, 8, width of operands, result and UART data
NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte
TIMEOUT_CYCLES, 200000, max clocks allowed between bytes of one command (about 4 frames at 5200 clk/bit)
NB_TIMER, 18, width of the timeout counter; must satisfy 2^NB_TIMER > TIMEOUT_CYCLES

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_rx_done  in  1  one-cycle strobe from UART rx: i_rx_data valid
i_rx_data  in  NB_DATA  received byte
i_tx_done  in  1  one-cycle strobe from UART tx: frame (incl. stop bit) sent
o_tx_start  out  1  one-cycle strobe: start transmitting o_tx_data
o_tx_data  out  NB_DATA  byte to transmit (registered)
o_data_a  out  NB_DATA  ALU operand A (registered)
o_data_b  out  NB_DATA  ALU operand B (registered)
o_opcode  out  NB_OP  ALU opcode (registered)
i_alu_result  in  NB_DATA  combinational ALU result
o_busy  out  1  high outside S_WAIT_A
o_err  out  1  one-cycle strobe on timeout abort

Behaviour:
- Reset (i_rst low, async): state S_WAIT_A; all outputs, data registers and timer cleared to 0.
- S_WAIT_A: on i_rx_done, o_data_a <= i_rx_data; go to S_WAIT_OP. Timer held at 0.
- S_WAIT_OP: on i_rx_done, o_opcode <= i_rx_data[NB_OP-1:0]; go to S_WAIT_B.
- S_WAIT_B: on i_rx_done, o_data_b <= i_rx_data; go to S_EXEC.
- S_EXEC: lasts exactly one cycle so the ALU settles on the registered operands. In this cycle: o_tx_data <= i_alu_result, o_tx_start <= 1; go to S_WAIT_TX.
- Latency: o_tx_start goes high on the 2nd rising edge after the clock that samples the third i_rx_done.
- S_WAIT_TX: o_tx_start back to 0 after one cycle. On i_tx_done, go to S_WAIT_A.
- Timeout counter: runs in S_WAIT_OP and S_WAIT_B; cleared on every accepted byte and on entering those states.
  - If the count reaches TIMEOUT_CYCLES-1 with no i_rx_done, the next state is S_WAIT_A and o_err pulses one cycle.
  - Captured operands are kept, not cleared.
  - If i_rx_done arrives on the same cycle as expiry, the byte wins: it is accepted, no error.
- i_rx_done during S_EXEC or S_WAIT_TX: byte dropped; no state or register change.
- Spurious i_tx_done outside S_WAIT_TX: ignored.
- o_data_a, o_data_b and o_opcode hold their values until overwritten, so the ALU inputs remain stable through transmission.
- o_busy = (state != S_WAIT_A), registered.
- Reset asserted mid-command or mid-transmission returns to S_WAIT_A next edge; o_tx_start forced 0.
- No timeout in S_WAIT_TX; the transmitter is trusted to complete.

Decomposition:
- Shared package (uart_alu_pkg): state encoding localparams (S_WAIT_A, S_WAIT_OP, S_WAIT_B, S_EXEC, S_WAIT_TX, 3 bits) and default NB_DATA/NB_OP.
- One natural sub-module: uart_alu_timeout, a loadable down-counter with clear/enable inputs and an expire strobe.
- FSM and data registers remain in uart_alu_ctrl.

Test Plan:
1. Bench models the ALU as an adder. Bytes 0x53, 0x2B, 0x01 with 10 cycles between strobes:
   - o_data_a=0x53, o_opcode=0x2B, o_data_b=0x01.
   - o_tx_start pulses 2 cycles after the 3rd strobe with o_tx_data=0x54.
   - o_busy stays high until i_tx_done.
2. Send 0x10 then 0x20, then silence for TIMEOUT_CYCLES (override to 100 for the bench):
   - o_err pulses once at cycle 100 and state returns to S_WAIT_A.
   - A following full command 0x05, 0x20, 0x03 yields o_tx_data=0x08.
3. With timeout at 100, i_rx_done arrives exactly on the expiry cycle in S_WAIT_B: no o_err; command completes.
4. Extra i_rx_done (0xFF) while in S_WAIT_TX:
   - Dropped; o_data_a, o_data_b and o_opcode unchanged.
   - After i_tx_done the block waits for a fresh operand A.
5. Reset (i_rst low for 3 cycles, asynchronous) pulsed in S_WAIT_TX and in S_WAIT_B:
   - Outputs go to 0 immediately; o_tx_start never asserts.
   - Idle in S_WAIT_A after release.
6. Two back-to-back commands (0xFF+0x01, then 0x7F+0x7F, adder model): o_tx_data=0x00, then 0xFE; exactly two o_tx_start pulses.
